adder_tree_acc: RTL and testbench
=================================

Name: adder_tree_acc

Overview:
Parametrised, fully pipelined unsigned adder tree with a ready/valid handshake on both sides and an optional frame accumulator. It sums NUM lanes per beat and can also sum successive beats up to a `last` marker. Output overflow is either saturated or wrapped, and is always flagged. It is the next-generation replacement for the fixed recursive adders in the datapath: it supports any NUM (including non-powers of two) and tolerates downstream backpressure.

Parameters:
BITS, 8, width of each unsigned input lane
NUM, 16, number of input lanes; must be >= 2 and need not be a power of two
OBITS, 16, output/accumulator width; must be >= BITS+clog2(NUM)
ACC, 1, 1 = accumulate beats until `last`; 0 = every beat produces an output (`last` ignored, treated as 1)
SAT, 1, 1 = saturate the accumulator to 2^OBITS-1 on overflow; 0 = wrap modulo 2^OBITS

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
valid  input  1  input beat valid
ready  output  1  input beat accepted when valid & ready
last  input  1  final beat of the frame, qualified by valid
data_in  input  NUM*BITS  lane i at [i*BITS +: BITS], unsigned
o  output  OBITS  frame (or beat) sum
valid_out  output  1  o valid
ready_out  input  1  downstream accept
overflow  output  1  sum for this output exceeded 2^OBITS-1; qualified by valid_out

Behaviour:
- Reset: one clk edge with rst=1 clears the following.
  - o=0, valid_out=0, overflow=0.
  - All pipeline valid bits and `last` bits.
  - Accumulator = 0, first-beat flag = 1.
- Reset mid-frame discards partial frames and in-flight beats. No output is produced for them.
- Global stall: en = !valid_out | ready_out, and ready = en (combinational from valid_out/ready_out only; never depends on valid).
- All pipeline registers advance only when en=1. While en=0, every register holds.
- Bubbles propagate as valid=0 stages.
- Tree structure:
  - L = clog2(NUM) registered levels.
  - Level k pairs adjacent operands; an odd leftover operand is registered through unchanged.
  - Each level grows width by 1 bit, so the tree itself never overflows.
  - Each level carries valid and last alongside the data.
- Accumulate stage (tree output valid and en=1):
  - sum = (first ? 0 : acc) + tree_out, computed at OBITS+1 bits.
  - ovf_beat = sum[OBITS]. Sticky ovf = (first ? 0 : ovf) | ovf_beat.
  - When SAT=1 and ovf_beat: acc = 2^OBITS-1, and stays there for further beats of the frame (saturation is sticky).
  - When SAT=0: acc = sum[OBITS-1:0].
  - If last (or ACC=0): load o, overflow and valid_out=1; set first=1; clear acc and ovf.
  - Otherwise: update acc and ovf, set first=0, no output.
- Output register:
  - valid_out clears when ready_out=1 and no new result is loaded.
  - A new result can load in the same cycle the old one is accepted (back-to-back throughput of 1 result/cycle).
- Latency: L+1 cycles from acceptance of the last beat to valid_out=1 with no stall. NUM=16 gives 5; NUM=5 gives 4.
- Throughput: 1 beat/cycle whenever ready_out=1.
- Data ordering is strictly preserved.
- o and overflow must remain stable while valid_out=1 and ready_out=0.
- valid=1 with ready=0 means the beat is not taken. The source must hold data_in and last stable until accepted.
- A frame may be a single beat (last on its first beat).
- Frame length is unbounded. Accumulator behaviour beyond 2^OBITS follows SAT.

Test Plan:
1. NUM=16, BITS=8, OBITS=16, ready_out=1; one beat, all lanes 0xFF, last=1 -> 5 cycles later o=4080, valid_out high exactly 1 cycle, overflow=0.
2. Three beats with all lanes 1, then 2, then 3; last on the 3rd -> single output o=96, no valid_out after beats 1–2.
3. Eight single-beat frames, frame n has all lanes = n (n=1..8); ready_out toggles 1,0,0,1,... -> outputs 16,32,...,128 in order, none lost or duplicated; o stable while ready_out=0; ready low whenever valid_out & !ready_out.
4. 17 beats of all-0xFF with last on the 17th (true sum 69360) -> SAT=1: o=65535, overflow=1; SAT=0: o=3824, overflow=1; the next frame (1 beat of all 1s) gives o=16, overflow=0.
5. Two beats without last, rst pulsed 1 cycle, then one beat of all 5s with last -> exactly one output, o=80; no output from the pre-reset beats; o=0 and valid_out=0 during and immediately after reset.
6. NUM=5, ACC=0, lanes 1,2,3,4,5 on consecutive beats (values incremented by 1 per beat) -> o=15, 20, 25, ... each 4 cycles after its beat, one per cycle.

Source files
------------

// File: rtl/adder_tree_acc_if.sv
// Beat-side and result-side handshake bundle for adder_tree_acc.
// The master modport is the data source/sink; the slave modport is the adder.
interface adder_tree_acc_if #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned NUM   = 16,
    parameter int unsigned OBITS = 16
);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [NUM*BITS-1:0]   data_in;
    logic [OBITS-1:0]      o;
    logic                  valid_out;
    logic                  ready_out;
    logic                  overflow;

    modport master (
        output valid, last, data_in, ready_out,
        input  ready, o, valid_out, overflow
    );

    modport slave (
        input  valid, last, data_in, ready_out,
        output ready, o, valid_out, overflow
    );
endinterface

// File: rtl/adder_tree_acc.sv
// Pipelined unsigned adder tree over NUM lanes with an optional frame accumulator.
// One global enable stalls every stage when the result register is full and not accepted.
module adder_tree_acc #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned NUM   = 16,
    parameter int unsigned OBITS = 16,
    parameter int unsigned ACC   = 1,
    parameter int unsigned SAT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    adder_tree_acc_if.slave    bus
);
    localparam int unsigned L      = $clog2(NUM);
    localparam int unsigned TW     = BITS + L;
    localparam bit          ACC_EN = (ACC != 0);
    localparam bit          SAT_EN = (SAT != 0);

    // Operand count entering level k (level 0 is the raw lanes).
    function automatic int unsigned lvl_cnt(input int unsigned k);
        int unsigned n;
        n = NUM;
        for (int unsigned i = 0; i < k; i++) n = (n + 1) / 2;
        return n;
    endfunction

    logic en;
    assign en        = ~bus.valid_out | bus.ready_out;
    assign bus.ready = en;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int unsigned NIN  = lvl_cnt(k - 1);
        localparam int unsigned NOUT = lvl_cnt(k);
        localparam int unsigned IW   = BITS + k - 1;

        logic [NIN-1:0][IW-1:0]    opnd;
        logic [2*NOUT-1:0][IW-1:0] opnd_pad;
        logic                      src_valid;
        logic                      src_last;
        logic [NOUT-1:0][IW:0]     sum_d;
        logic [NOUT-1:0][IW:0]     sum_q;
        logic                      valid_d;
        logic                      valid_q;
        logic                      last_d;
        logic                      last_q;

        if (k == 1) begin : g_src
            assign opnd      = bus.data_in;
            assign src_valid = bus.valid;
            assign src_last  = bus.last | ~ACC_EN;
        end else begin : g_src
            assign opnd      = g_lvl[k-1].sum_q;
            assign src_valid = g_lvl[k-1].valid_q;
            assign src_last  = g_lvl[k-1].last_q;
        end

        // A zero partner turns the odd leftover operand into a pass-through.
        assign opnd_pad = (2*NOUT*IW)'(opnd);

        always_comb begin
            sum_d   = '0;
            valid_d = src_valid;
            last_d  = src_last;
            for (int unsigned j = 0; j < NOUT; j++) begin
                sum_d[j] = (IW+1)'(opnd_pad[2*j]) + (IW+1)'(opnd_pad[2*j+1]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (en) begin
                valid_q <= valid_d;
                last_q  <= last_d;
            end
        end

        always_ff @(posedge clk) begin
            if (en) sum_q <= sum_d;
        end
    end

    logic [TW-1:0] tree_data;
    logic          tree_valid;
    logic          tree_last;

    assign tree_data  = g_lvl[L].sum_q[0];
    assign tree_valid = g_lvl[L].valid_q;
    assign tree_last  = g_lvl[L].last_q;

    logic [OBITS-1:0] acc_d, acc_q;
    logic             ovf_d, ovf_q;
    logic             first_d, first_q;
    logic [OBITS-1:0] o_d, o_q;
    logic             overflow_d, overflow_q;
    logic             valid_out_d, valid_out_q;
    logic [OBITS:0]   acc_sum;
    logic             ovf_beat;
    logic             ovf_all;
    logic [OBITS-1:0] acc_next;

    // Frame accumulation and result register; saturation sticks once overflow is seen.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        first_d     = first_q;
        o_d         = o_q;
        overflow_d  = overflow_q;
        valid_out_d = valid_out_q & ~bus.ready_out;
        acc_sum     = (first_q ? '0 : {1'b0, acc_q}) + (OBITS+1)'(tree_data);
        ovf_beat    = acc_sum[OBITS];
        ovf_all     = (ovf_q & ~first_q) | ovf_beat;
        acc_next    = (SAT_EN && ovf_all) ? '1 : acc_sum[OBITS-1:0];
        if (tree_valid && en) begin
            if (tree_last) begin
                o_d         = acc_next;
                overflow_d  = ovf_all;
                valid_out_d = 1'b1;
                first_d     = 1'b1;
                acc_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d   = acc_next;
                ovf_d   = ovf_all;
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            o_q         <= '0;
            overflow_q  <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            o_q         <= o_d;
            overflow_q  <= overflow_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.o         = o_q;
    assign bus.overflow  = overflow_q;
    assign bus.valid_out = valid_out_q;
endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: saturating and wrapping 16-lane accumulators side by side,
// plus a 5-lane per-beat instance; frame-sum reference model and constant vector table.
module tb_adder_tree_acc;
    localparam int unsigned BITS    = 8;
    localparam int unsigned NUM     = 16;
    localparam int unsigned OBITS   = 16;
    localparam int          LAT     = 5;
    localparam int unsigned NUM_C   = 5;
    localparam int unsigned OBITS_C = 12;
    localparam int          LAT_C   = 4;
    localparam longint      MAX_A   = 65535;
    localparam longint      MAX_C   = 4095;

    typedef struct {
        longint sum;
        int     due;
    } exp_t;

    typedef struct {
        logic [7:0] lane;
        int         beats;
        longint     exp_sat;
        longint     exp_wrap;
        bit         exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_tree_acc_if #(.BITS(BITS), .NUM(NUM),   .OBITS(OBITS))   if_a ();
    adder_tree_acc_if #(.BITS(BITS), .NUM(NUM),   .OBITS(OBITS))   if_b ();
    adder_tree_acc_if #(.BITS(BITS), .NUM(NUM_C), .OBITS(OBITS_C)) if_c ();

    assign if_b.valid     = if_a.valid;
    assign if_b.last      = if_a.last;
    assign if_b.data_in   = if_a.data_in;
    assign if_b.ready_out = if_a.ready_out;

    adder_tree_acc #(.BITS(BITS), .NUM(NUM), .OBITS(OBITS), .ACC(1), .SAT(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    adder_tree_acc #(.BITS(BITS), .NUM(NUM), .OBITS(OBITS), .ACC(1), .SAT(0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    adder_tree_acc #(.BITS(BITS), .NUM(NUM_C), .OBITS(OBITS_C), .ACC(0), .SAT(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    function automatic void check(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic longint lanes_sum(input logic [NUM*BITS-1:0] d, input int n);
        longint s;
        s = 0;
        for (int i = 0; i < n; i++) s += longint'(d[i*BITS +: BITS]);
        return s;
    endfunction

    // Reference model state
    exp_t   exp_a[$];
    exp_t   exp_c[$];
    longint part_a;
    int     n_out_a = 0;
    int     n_out_c = 0;
    longint o_log_a[$];
    longint o_log_c[$];
    int     t_log_c[$];
    longint last_o_a, last_o_b;
    longint last_ovf_a, last_ovf_b;
    bit     chk_lat_a = 1'b1;
    bit     chk_lat_c = 1'b1;
    bit     hold_a = 1'b0;
    longint hold_o_a, hold_o_b, hold_ovf_a;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst) begin
            part_a = 0;
            exp_a.delete();
            hold_a = 1'b0;
        end else begin
            check("ready_a", longint'(if_a.ready), longint'(!(if_a.valid_out && !if_a.ready_out)));
            check("valid_out_b", longint'(if_b.valid_out), longint'(if_a.valid_out));
            if (hold_a) begin
                check("hold_valid_a", longint'(if_a.valid_out), 1);
                check("hold_o_a", longint'(if_a.o), hold_o_a);
                check("hold_o_b", longint'(if_b.o), hold_o_b);
                check("hold_ovf_a", longint'(if_a.overflow), hold_ovf_a);
            end
            hold_a     = if_a.valid_out && !if_a.ready_out;
            hold_o_a   = longint'(if_a.o);
            hold_o_b   = longint'(if_b.o);
            hold_ovf_a = longint'(if_a.overflow);
            if (if_a.valid_out && if_a.ready_out) begin
                n_out_a++;
                last_o_a   = longint'(if_a.o);
                last_o_b   = longint'(if_b.o);
                last_ovf_a = longint'(if_a.overflow);
                last_ovf_b = longint'(if_b.overflow);
                o_log_a.push_back(longint'(if_a.o));
                if (exp_a.size() == 0) begin
                    check("unexpected_out_a", longint'(if_a.valid_out), 0);
                end else begin
                    e = exp_a.pop_front();
                    check("sb_o_sat", longint'(if_a.o), (e.sum > MAX_A) ? MAX_A : e.sum);
                    check("sb_o_wrap", longint'(if_b.o), e.sum % (MAX_A + 1));
                    check("sb_ovf_sat", longint'(if_a.overflow), longint'(e.sum > MAX_A));
                    check("sb_ovf_wrap", longint'(if_b.overflow), longint'(e.sum > MAX_A));
                    if (chk_lat_a) check("latency_a", longint'(cyc), longint'(e.due));
                end
            end
            if (if_a.valid && if_a.ready) begin
                part_a += lanes_sum(if_a.data_in, NUM);
                if (if_a.last) begin
                    exp_a.push_back('{sum: part_a, due: cyc + LAT});
                    part_a = 0;
                end
            end
        end
    end

    always @(negedge clk) begin : mon_c
        exp_t e;
        if (rst) begin
            exp_c.delete();
        end else begin
            check("ready_c", longint'(if_c.ready), longint'(!(if_c.valid_out && !if_c.ready_out)));
            if (if_c.valid_out && if_c.ready_out) begin
                n_out_c++;
                o_log_c.push_back(longint'(if_c.o));
                t_log_c.push_back(cyc);
                if (exp_c.size() == 0) begin
                    check("unexpected_out_c", longint'(if_c.valid_out), 0);
                end else begin
                    e = exp_c.pop_front();
                    check("sb_o_c", longint'(if_c.o), (e.sum > MAX_C) ? MAX_C : e.sum);
                    check("sb_ovf_c", longint'(if_c.overflow), longint'(e.sum > MAX_C));
                    if (chk_lat_c) check("latency_c", longint'(cyc), longint'(e.due));
                end
            end
            if (if_c.valid && if_c.ready)
                exp_c.push_back('{sum: lanes_sum((NUM*BITS)'(if_c.data_in), NUM_C), due: cyc + LAT_C});
        end
    end

    task automatic send_a(input logic [NUM*BITS-1:0] d, input logic l);
        int t;
        if_a.data_in = d;
        if_a.last    = l;
        if_a.valid   = 1'b1;
        t = 0;
        @(negedge clk);
        while (!if_a.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_a", longint'(if_a.ready), 1);
        @(posedge clk);
        #1;
        if_a.valid = 1'b0;
        if_a.last  = 1'b0;
    endtask

    task automatic send_c(input logic [NUM_C*BITS-1:0] d, input logic l);
        int t;
        if_c.data_in = d;
        if_c.last    = l;
        if_c.valid   = 1'b1;
        t = 0;
        @(negedge clk);
        while (!if_c.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_c", longint'(if_c.ready), 1);
        @(posedge clk);
        #1;
        if_c.valid = 1'b0;
        if_c.last  = 1'b0;
    endtask

    task automatic wait_a(input int target);
        for (int t = 0; t < 200 && n_out_a < target; t++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        check("out_count_a", longint'(n_out_a), longint'(target));
    endtask

    task automatic wait_c(input int target);
        for (int t = 0; t < 200 && n_out_c < target; t++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        check("out_count_c", longint'(n_out_c), longint'(target));
    endtask

    function automatic logic [NUM*BITS-1:0] fill(input logic [7:0] v);
        return {NUM{v}};
    endfunction

    initial begin
        vec_t vt[10];
        bit   pat[4];
        bit   done;
        int   n0;
        int   base;
        logic [NUM*BITS-1:0]   d;
        logic [NUM_C*BITS-1:0] dc;

        vt[0] = '{8'hFF,  1,  4080,  4080, 1'b0};
        vt[1] = '{8'h01,  1,    16,    16, 1'b0};
        vt[2] = '{8'h05,  1,    80,    80, 1'b0};
        vt[3] = '{8'hFF, 17, 65535,  3824, 1'b1};
        vt[4] = '{8'h01,  1,    16,    16, 1'b0};
        vt[5] = '{8'h00,  3,     0,     0, 1'b0};
        vt[6] = '{8'h10, 16,  4096,  4096, 1'b0};
        vt[7] = '{8'hFF, 16, 65280, 65280, 1'b0};
        vt[8] = '{8'h80, 32, 65535,     0, 1'b1};
        vt[9] = '{8'hFF, 18, 65535,  7904, 1'b1};
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst          = 1'b1;
        if_a.valid   = 1'b0; if_a.last = 1'b0; if_a.data_in = '0; if_a.ready_out = 1'b1;
        if_c.valid   = 1'b0; if_c.last = 1'b0; if_c.data_in = '0; if_c.ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_o_a", longint'(if_a.o), 0);
        check("rst_vo_a", longint'(if_a.valid_out), 0);
        check("rst_ovf_a", longint'(if_a.overflow), 0);
        check("rst_o_b", longint'(if_b.o), 0);
        check("rst_vo_b", longint'(if_b.valid_out), 0);
        check("rst_o_c", longint'(if_c.o), 0);
        check("rst_vo_c", longint'(if_c.valid_out), 0);
        check("rst_ovf_c", longint'(if_c.overflow), 0);

        // Uniform-lane frames against hand-computed sums
        for (int i = 0; i < 10; i++) begin
            n0 = n_out_a;
            for (int b = 0; b < vt[i].beats; b++) send_a(fill(vt[i].lane), b == vt[i].beats - 1);
            wait_a(n0 + 1);
            check("vec_o_sat", last_o_a, vt[i].exp_sat);
            check("vec_o_wrap", last_o_b, vt[i].exp_wrap);
            check("vec_ovf_sat", last_ovf_a, longint'(vt[i].exp_ovf));
            check("vec_ovf_wrap", last_ovf_b, longint'(vt[i].exp_ovf));
        end

        // Three-beat frame 1,2,3
        n0 = n_out_a;
        send_a(fill(8'd1), 1'b0);
        send_a(fill(8'd2), 1'b0);
        send_a(fill(8'd3), 1'b1);
        wait_a(n0 + 1);
        check("frame3_o", last_o_a, 96);
        check("frame3_ovf", last_ovf_a, 0);

        // Eight single-beat frames under a 1,0,0,1 ready_out pattern
        chk_lat_a = 1'b0;
        n0   = n_out_a;
        base = o_log_a.size();
        done = 1'b0;
        fork
            begin
                for (int n = 1; n <= 8; n++) send_a(fill(8'(n)), 1'b1);
                done = 1'b1;
            end
            begin
                for (int t = 0; !done && t < 400; t++) begin
                    if_a.ready_out = pat[t % 4];
                    @(posedge clk);
                    #1;
                end
                if_a.ready_out = 1'b1;
            end
        join
        wait_a(n0 + 8);
        for (int n = 0; n < 8 && base + n < o_log_a.size(); n++)
            check("order_o", o_log_a[base + n], longint'(16 * (n + 1)));
        chk_lat_a = 1'b1;

        // Reset in the middle of a frame
        send_a(fill(8'hFF), 1'b0);
        send_a(fill(8'hFF), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_vo", longint'(if_a.valid_out), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_o", longint'(if_a.o), 0);
        check("rst_mid_vo_after", longint'(if_a.valid_out), 0);
        n0 = n_out_a;
        send_a(fill(8'd5), 1'b1);
        wait_a(n0 + 1);
        check("rst_mid_frame", last_o_a, 80);

        // Random frames with random backpressure
        chk_lat_a = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    for (int j = 0; j < int'(NUM); j++) d[j*BITS +: BITS] = 8'($urandom);
                    send_a(d, ($urandom_range(0, 3) == 0) || (i == 299));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    if_a.ready_out = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                if_a.ready_out = 1'b1;
            end
        join
        for (int t = 0; t < 200 && exp_a.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_a", longint'(exp_a.size()), 0);

        // Per-beat 5-lane instance: lanes k+1..k+5 on consecutive beats, last held low
        n0   = n_out_c;
        base = o_log_c.size();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < int'(NUM_C); i++) dc[i*BITS +: BITS] = 8'(k + 1 + i);
            send_c(dc, 1'b0);
        end
        wait_c(n0 + 10);
        for (int k = 0; k < 10 && base + k < o_log_c.size(); k++) begin
            check("beat_o_c", o_log_c[base + k], longint'(15 + 5 * k));
            if (k > 0) check("beat_gap_c", longint'(t_log_c[base + k] - t_log_c[base + k - 1]), 1);
        end

        chk_lat_c = 1'b0;
        n0   = n_out_c;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    for (int j = 0; j < int'(NUM_C); j++) dc[j*BITS +: BITS] = 8'($urandom);
                    send_c(dc, 1'($urandom_range(0, 1)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    if_c.ready_out = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                if_c.ready_out = 1'b1;
            end
        join
        wait_c(n0 + 200);
        check("drain_c", longint'(exp_c.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
